// File: rtl/mealy_seq_detect.sv
// -----------------------------------------------------------------------------
// mealy_seq_detect
//
// Purpose:
//   Mealy-type serial detector for the bit pattern "101" on a 1-bit stream
//   sampled once per clock. The detect flag z is combinational. It is high
//   in the same cycle that the final '1' of the pattern is present on x.
//   With OVERLAP=1 that final '1' also starts the next match. With
//   OVERLAP=0 the detector returns to idle after a match.
//
// Parameters:
//   OVERLAP  1 = overlapping detection (default), 0 = non-overlapping
//
// Ports:
//   clk  in   system clock, state updates on the rising edge
//   rst  in   asynchronous, active-high reset
//   x    in   serial data bit, sampled at each rising clk edge
//   z    out  detect flag: (current_state == S2) & x & ~rst
// -----------------------------------------------------------------------------
module mealy_seq_detect #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    // Binary encoding. The value 2'd3 is unused; the next-state default
    // sends it back to S0.
    typedef enum logic [1:0] {
        S0 = 2'd0,  // idle, nothing matched
        S1 = 2'd1,  // "1" seen
        S2 = 2'd2   // "10" seen
    } state_t;

    // Kept under this name so it can be displayed hierarchically when debugging.
    state_t current_state;
    state_t next_state;

    // State register.
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_state <= S0;
        end else begin
            current_state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case statement, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        next_state = S0;
        case (current_state)
            S0: next_state = x ? S1 : S0;
            // "11" keeps the latest '1' as a possible pattern start.
            S1: next_state = x ? S1 : S2;
            // "101" completes here. "100" breaks the partial match.
            S2: begin
                if (x) begin
                    next_state = OVERLAP ? S1 : S0;
                end else begin
                    next_state = S0;
                end
            end
            default: next_state = S0;
        endcase
    end

    // Mealy output. It uses rst directly, so z drops as soon as reset is
    // asserted and does not wait for the state register to clear.
    always_comb begin
        z = (current_state == S2) && x && !rst;
    end

endmodule

// File: tb/tb_mealy_seq_detect.sv
// -----------------------------------------------------------------------------
// tb_mealy_seq_detect
//
// Self-checking bench for mealy_seq_detect. Two instances share the same
// stimulus: one with OVERLAP=1 and one with OVERLAP=0.
// Inputs are driven 1 time unit after each rising edge. Expected values are
// pushed to a scoreboard queue at the same time. They are popped and
// compared at the following falling edge.
// -----------------------------------------------------------------------------
module tb_mealy_seq_detect;

    logic clk;
    logic rst;
    logic x;
    logic z_ov;
    logic z_no;

    int errors = 0;
    int checks = 0;

    mealy_seq_detect #(.OVERLAP(1'b1)) dut_ov (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_ov)
    );

    mealy_seq_detect #(.OVERLAP(1'b0)) dut_no (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle. State values are the ones that hold
    // while the cycle's input is applied, before the next rising edge.
    typedef struct {
        logic       z_ov;
        logic       z_no;
        logic [1:0] st_ov;
        logic [1:0] st_no;
    } exp_t;

    typedef struct {
        logic rst;
        logic x;
        exp_t e;
    } vec_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [1:0] actual,
                         input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one vector and push its expectation. At the falling edge, pop
    // the expectation and compare both instances against it.
    task automatic apply(input string tag, input logic r, input logic xv,
                         input exp_t e);
        exp_t got;
        @(posedge clk);
        #1;
        rst = r;
        x   = xv;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            check({tag, " z_ov"},  {1'b0, z_ov}, {1'b0, got.z_ov});
            check({tag, " z_no"},  {1'b0, z_no}, {1'b0, got.z_no});
            check({tag, " st_ov"}, dut_ov.current_state, got.st_ov);
            check({tag, " st_no"}, dut_no.current_state, got.st_no);
        end
    endtask

    // Reference model for the random section.
    function automatic int model_next(input int s, input logic xv,
                                      input bit ov);
        if (s == 0) return xv ? 1 : 0;
        if (s == 1) return xv ? 1 : 2;
        if (s == 2) return xv ? (ov ? 1 : 0) : 0;
        return 0;
    endfunction

    // Global time limit, so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    vec_t tbl[$];

    initial begin
        int ms_ov;
        int ms_no;
        logic r;
        logic xv;
        exp_t e;

        rst = 1'b1;
        x   = 1'b0;

        // Fields: {rst, x, {z_ov, z_no, st_ov, st_no}}.
        // Reset with x toggling, release, then the stream 1,0,1,0,1.
        tbl.push_back('{1'b1, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b1, 1'b0, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd1, 2'd1}});
        tbl.push_back('{1'b0, 1'b1, '{1'b1, 1'b1, 2'd2, 2'd2}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd1, 2'd0}});
        tbl.push_back('{1'b0, 1'b1, '{1'b1, 1'b0, 2'd2, 2'd0}});
        // Reset, then the non-pattern 1,1,0,0,1.
        tbl.push_back('{1'b1, 1'b0, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd1, 2'd1}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd1, 2'd1}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd2, 2'd2}});
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0}});
        // Non-pattern 0,0,0,0.
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd1, 2'd1}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd2, 2'd2}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 2'd0}});
        // "11" stays in S1, then "01" detects on the final 1.
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0}});
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd1, 2'd1}});
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd1, 2'd1}});
        tbl.push_back('{1'b0, 1'b1, '{1'b1, 1'b1, 2'd2, 2'd2}});
        tbl.push_back('{1'b0, 1'b1, '{1'b0, 1'b0, 2'd1, 2'd0}});
        // Both instances are now in S1. Move them to S2.
        tbl.push_back('{1'b0, 1'b0, '{1'b0, 1'b0, 2'd1, 2'd1}});

        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].x, tbl[i].e);
        end

        // Async reset mid-match. Both instances are in S2. Drive x=1,
        // confirm detection, then assert rst between clock edges.
        @(posedge clk);
        #1;
        x = 1'b1;
        #1;
        check("async pre z_ov", {1'b0, z_ov}, 2'd1);
        check("async pre z_no", {1'b0, z_no}, 2'd1);
        check("async pre st_ov", dut_ov.current_state, 2'd2);
        #1;
        rst = 1'b1;
        #1;
        check("async z_ov immediate", {1'b0, z_ov}, 2'd0);
        check("async z_no immediate", {1'b0, z_no}, 2'd0);
        check("async st_ov immediate", dut_ov.current_state, 2'd0);
        check("async st_no immediate", dut_no.current_state, 2'd0);
        // Release, then apply 0,1. There must be no detection.
        apply("post_async_rst", 1'b1, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0});
        apply("post_async_x0",  1'b0, 1'b0, '{1'b0, 1'b0, 2'd0, 2'd0});
        apply("post_async_x1",  1'b0, 1'b1, '{1'b0, 1'b0, 2'd0, 2'd0});

        // Random stream checked against the reference model. The stream
        // starts with reset, so the model begins in a known state.
        ms_ov = 0;
        ms_no = 0;
        for (int i = 0; i < 32; i++) begin
            r  = (i == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
            xv = 1'($urandom_range(0, 1));
            if (r) begin
                ms_ov = 0;
                ms_no = 0;
            end
            e.st_ov = 2'(ms_ov);
            e.st_no = 2'(ms_no);
            e.z_ov  = (ms_ov == 2) && xv && !r;
            e.z_no  = (ms_no == 2) && xv && !r;
            apply($sformatf("rnd%0d", i), r, xv, e);
            ms_ov = r ? 0 : model_next(ms_ov, xv, 1'b1);
            ms_no = r ? 0 : model_next(ms_no, xv, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_seq_detect.md
Name: mealy_seq_detect

Overview:
- Mealy-type serial detector for the bit pattern "101" on a 1-bit input stream, sampled once per clock.
- Output z asserts combinationally in the same cycle that the final '1' of the pattern is present on x.
- Used as a small control/pattern-recognition leaf block; detection overlaps by default, so a trailing '1' can begin the next match.

Parameters:
- OVERLAP, 1, 1 = overlapping detection (after a match, the final '1' counts as the first bit of the next pattern); 0 = non-overlapping (after a match, restart from idle).

Ports:
- clk  input  1  system clock; state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- x    input  1  serial data bit, sampled at each rising clk edge
- z    output 1  detect flag; 1 when the current state is S2 and x = 1 (Mealy, combinational)

Behaviour:
- State register named current_state, 2 bits wide, binary encoded. It must remain hierarchically visible under that name for debug display.
  - S0 = 0: idle, nothing matched.
  - S1 = 1: "1" seen.
  - S2 = 2: "10" seen.
  - Encoding 3 is unused and recovers to S0 on the next clock.
- Reset:
  - rst = 1 forces current_state to S0 immediately, independent of clk.
  - While rst = 1, z = 0 regardless of x.
  - Reset asserted mid-sequence discards any partial match.
  - After rst deasserts, detection starts fresh from S0 on the next rising edge.
- Transitions on rising clk edge (rst = 0):
  - S0: x=1 -> S1; x=0 -> S0.
  - S1: x=1 -> S1 (the "11" case keeps the latest '1'); x=0 -> S2.
  - S2: x=1 -> S1 if OVERLAP=1, S0 if OVERLAP=0; x=0 -> S0 (pattern "100" breaks the match).
- Output:
  - z = (current_state == S2) & x & ~rst, purely combinational.
  - z has no clock latency: it is valid once x settles within the cycle and is meaningful at the following rising edge (or when sampled at the falling edge).
  - z may glitch if x changes mid-cycle; the consumer samples it synchronously.
- Latency: the first detection occurs during the third input bit after reset, i.e. at the 3rd sampled bit of "101".
- Next-state logic and output logic are kept separate from the state register: one sequential process for the register, combinational logic for next-state and z.
- No other outputs and no internal counters.

Test Plan:
- Reset check: rst=1 with x toggling for 2 cycles -> current_state=0 and z=0 throughout. Release rst, apply x=1 -> state becomes 1 after the edge, z=0.
- Basic detect: from S0 apply x = 1,0,1 on successive cycles -> z=0,0,1 in those cycles; current_state sequence 0 -> 1 -> 2 while z=1 is asserted.
- Overlap (OVERLAP=1): x = 1,0,1,0,1 -> z = 0,0,1,0,1. With OVERLAP=0 the same stream gives z = 0,0,1,0,0.
- Non-patterns: x = 1,1,0,0,1 and x = 0,0,0,0 -> z stays 0. After "11" the state remains S1, and a following "01" then yields z=1 on that final 1.
- Async reset mid-match: in S2, assert rst between clock edges with x=1 -> state goes to 0 immediately and z drops to 0 immediately. After release, x = 0,1 gives no detection.
- Long random stream of ~32 vectors (rst, x, expected z) compared against a reference model at each falling edge -> zero mismatches.
